prefix_adder_pipe: RTL

//  Parametrised, pipelined Kogge-Stone prefix adder/subtractor; the generalised successor of our fixed 4-bit prefix adder.

---
 rtl/prefix_adder_pipe_if.sv | 26 ++
 rtl/prefix_adder_pipe.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/prefix_adder_pipe_if.sv
// rtl/prefix_adder_pipe_if.sv - operand/result handshake bundle for prefix_adder_pipe
interface prefix_adder_pipe_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, sum, cout, ovf
    );

    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, sum, cout, ovf
    );
endinterface

// File: rtl/prefix_adder_pipe.sv
// rtl/prefix_adder_pipe.sv - pipelined Kogge-Stone adder/subtractor with valid/ready flow control
module prefix_adder_pipe #(
    parameter int WIDTH       = 32,
    parameter int LVL_PER_STG = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    prefix_adder_pipe_if.slave  bus
);
    localparam int LOG2W = $clog2(WIDTH);
    localparam int S     = (LOG2W + LVL_PER_STG - 1) / LVL_PER_STG;

    typedef logic [WIDTH-1:0] vec_t;

    // Ranks 0..S-1 carry G/P/sum-P/c0; rank S is the output register set.
    vec_t         g_q  [S];
    vec_t         g_d  [S];
    vec_t         p_q  [S];
    vec_t         p_d  [S];
    vec_t         ps_q [S];
    vec_t         ps_d [S];
    logic [S-1:0] c0_q, c0_d;
    logic [S:0]   v_q, v_d;
    logic [S:0]   ld;
    vec_t         sum_q, sum_d;
    logic         cout_q, cout_d;
    logic         ovf_q, ovf_d;

    vec_t         b_eff;
    logic         c0_in;
    vec_t         g_fin;
    vec_t         carry;

    function automatic vec_t low_ones(input int k);
        return (vec_t'(1) << (1 << k)) - vec_t'(1);
    endfunction

    function automatic vec_t kogge_p(input int r, input vec_t p_in);
        vec_t p;
        p = p_in;
        for (int k = 0; k < LOG2W; k++) begin
            if (k / LVL_PER_STG == r - 1)
                p = p & ((p << (1 << k)) | low_ones(k));
        end
        return p;
    endfunction

    function automatic vec_t kogge_g(input int r, input vec_t g_in, input vec_t p_in);
        vec_t g;
        vec_t p;
        g = g_in;
        p = p_in;
        for (int k = 0; k < LOG2W; k++) begin
            if (k / LVL_PER_STG == r - 1) begin
                g = g | (p & (g << (1 << k)));
                p = p & ((p << (1 << k)) | low_ones(k));
            end
        end
        return g;
    endfunction

    // A rank loads when it or any rank downstream of it has a hole, or the consumer takes the result.
    always_comb begin
        for (int k = 0; k <= S; k++) begin
            ld[k] = bus.out_ready;
            for (int j = k; j <= S; j++) begin
                if (!v_q[j])
                    ld[k] = 1'b1;
            end
        end
    end

    always_comb begin
        v_d    = v_q;
        g_d    = g_q;
        p_d    = p_q;
        ps_d   = ps_q;
        c0_d   = c0_q;
        sum_d  = sum_q;
        cout_d = cout_q;
        ovf_d  = ovf_q;

        b_eff = bus.sub ? ~bus.b : bus.b;
        c0_in = bus.sub | bus.cin;

        // Carry-in is folded into bit 0 generate so the prefix tree needs no extra column.
        if (ld[0]) begin
            v_d[0]  = bus.in_valid;
            g_d[0]  = (bus.a & b_eff) | vec_t'((bus.a[0] ^ b_eff[0]) & c0_in);
            p_d[0]  = bus.a ^ b_eff;
            ps_d[0] = bus.a ^ b_eff;
            c0_d[0] = c0_in;
        end

        for (int r = 1; r < S; r++) begin
            if (ld[r]) begin
                v_d[r]  = v_q[r-1];
                g_d[r]  = kogge_g(r, g_q[r-1], p_q[r-1]);
                p_d[r]  = kogge_p(r, p_q[r-1]);
                ps_d[r] = ps_q[r-1];
                c0_d[r] = c0_q[r-1];
            end
        end

        g_fin = kogge_g(S, g_q[S-1], p_q[S-1]);
        carry = {g_fin[WIDTH-2:0], c0_q[S-1]};

        if (ld[S]) begin
            v_d[S] = v_q[S-1];
            if (v_q[S-1]) begin
                sum_d  = ps_q[S-1] ^ carry;
                cout_d = g_fin[WIDTH-1];
                ovf_d  = g_fin[WIDTH-2] ^ g_fin[WIDTH-1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_q    <= '0;
            g_q    <= '{default: '0};
            p_q    <= '{default: '0};
            ps_q   <= '{default: '0};
            c0_q   <= '0;
            sum_q  <= '0;
            cout_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            v_q    <= v_d;
            g_q    <= g_d;
            p_q    <= p_d;
            ps_q   <= ps_d;
            c0_q   <= c0_d;
            sum_q  <= sum_d;
            cout_q <= cout_d;
            ovf_q  <= ovf_d;
        end
    end

    assign bus.in_ready  = ld[0];
    assign bus.out_valid = v_q[S];
    assign bus.sum       = sum_q;
    assign bus.cout      = cout_q;
    assign bus.ovf       = ovf_q;
endmodule
